// File: rtl/clk_gen_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : clk_gen_pkg                                                   |
// | Description : Shared types and helpers for the clk_gen_multi divider.       |
// |               Lock FSM state encoding, channel limit, divide-ratio clamp.   |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
package clk_gen_pkg;

    // Upper bound on the number of output channels; also sizes cfg_ch.
    localparam int MAX_CH = 8;

    // Lock state machine: waiting for settling time, or running.
    typedef enum logic [0:0] {
        ST_LOCKING = 1'b0,
        ST_LOCKED  = 1'b1
    } lock_state_e;

    // Ratios of 0 and 1 cannot produce a toggling clock, so they run as 2.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_gen_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface   : clk_gen_multi_if                                              |
// | Description : Runtime divide-ratio reconfiguration handshake.               |
// |               A transfer occurs on a clock where cfg_valid & cfg_ready.     |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
interface clk_gen_multi_if
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = 8
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [$clog2(MAX_CH)-1:0] cfg_ch;
    logic [DIV_W-1:0]          cfg_div;

    // Requester side (testbench / configuration master).
    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    // Clock generator side.
    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/clk_gen_chan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_gen_chan                                                  |
// | Description : One divided-clock channel. Counts 0..D-1 while run_i is high, |
// |               drives clk_out high for the first D>>1 counts and a one-cycle |
// |               clk_en strobe on count 0. Restarts from count 0 whenever run  |
// |               rises so that all channels start phase aligned.               |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module clk_gen_chan
    import clk_gen_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  wire logic             clk_in1,
    input  wire logic             resetn,
    input  wire logic             run_i,
    input  wire logic [DIV_W-1:0] div_i,
    output logic                  clk_out_o,
    output logic                  clk_en_o
);

    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] half;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             run_q;
    logic             clk_out_q;
    logic             clk_en_q;

    assign d_eff = DIV_W'(clamp_div(32'(div_i)));
    assign half  = d_eff >> 1;

    // Next count: zero while stopped and on the first running cycle, else wrap at D-1.
    always_comb begin
        cnt_d = '0;
        if (run_i && run_q) begin
            cnt_d = (cnt_q >= d_eff - DIV_W'(1)) ? '0 : cnt_q + DIV_W'(1);
        end
    end

    // Counter and registered outputs; outputs describe the count held this cycle.
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            run_q     <= 1'b0;
            cnt_q     <= '0;
            clk_out_q <= 1'b0;
            clk_en_q  <= 1'b0;
        end else begin
            run_q     <= run_i;
            cnt_q     <= cnt_d;
            clk_out_q <= run_i && (cnt_d < half);
            clk_en_q  <= run_i && (cnt_d == '0);
        end
    end

    assign clk_out_o = clk_out_q;
    assign clk_en_o  = clk_en_q;

endmodule
`default_nettype wire

// File: rtl/clk_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_gen_multi                                                 |
// | Description : Multi-output clock divider. Produces NUM_CH divided clocks    |
// |               and matching clock-enable strobes from clk_in1, asserts       |
// |               locked after LOCK_CYCLES of settling, and restarts all        |
// |               channels phase aligned on every lock.                         |
// |               Optional runtime ratio updates: CLK_GEN_MULTI_RECONFIG_EN.    |
// |               Without it cfg_ready is 0 and ratios stay at DIV_INIT.        |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module clk_gen_multi
    import clk_gen_pkg::*;
#(
    parameter int                      NUM_CH      = 2,
    parameter int                      DIV_W       = 8,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {8'd4, 8'd2},
    parameter int                      LOCK_CYCLES = 16
) (
    input  wire logic              clk_in1,
    input  wire logic              resetn,
    clk_gen_multi_if.slave         cfg,
    output logic [NUM_CH-1:0]      clk_out,
    output logic [NUM_CH-1:0]      clk_en,
    output logic                   locked
);

    // A zero settling time still needs a one-bit counter to compare against.
    localparam int              LCW         = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    localparam logic [LCW-1:0]  LOCK_TARGET = LCW'(LOCK_CYCLES);

    lock_state_e      state_q;
    lock_state_e      state_d;
    logic [LCW-1:0]   lock_cnt_q;
    logic [LCW-1:0]   lock_cnt_d;
    logic             locked_q;
    logic             reconf;
    logic             run;
    logic [DIV_W-1:0] ratio [NUM_CH];

`ifdef CLK_GEN_MULTI_RECONFIG_EN
    logic             cfg_ready_q;
    logic             cfg_xfer;
    logic             cfg_ch_ok;
    logic [DIV_W-1:0] ratio_q [NUM_CH];

    assign cfg_xfer      = cfg.cfg_valid & cfg_ready_q;
    assign cfg_ch_ok     = (int'(cfg.cfg_ch) < NUM_CH);
    // Out-of-range channel transfers complete but change nothing.
    assign reconf        = cfg_xfer & cfg_ch_ok;
    assign cfg.cfg_ready = cfg_ready_q;

    // Ready only while locked; registered so cfg_* never reaches an output combinationally.
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            cfg_ready_q <= 1'b0;
        end else begin
            cfg_ready_q <= (state_d == ST_LOCKED);
        end
    end

    // Ratio registers: reset to DIV_INIT, updated on an accepted in-range transfer.
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CH; i++) begin
                ratio_q[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (reconf && (int'(cfg.cfg_ch) == i)) begin
                    ratio_q[i] <= cfg.cfg_div;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ratio
        assign ratio[i] = ratio_q[i];
    end
`else
    logic unused_cfg;

    assign unused_cfg    = ^{cfg.cfg_valid, cfg.cfg_ch, cfg.cfg_div};
    assign reconf        = 1'b0;
    assign cfg.cfg_ready = 1'b0;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ratio
        assign ratio[i] = DIV_INIT[i*DIV_W +: DIV_W];
    end
`endif

    // Lock FSM next state: settle for LOCK_CYCLES, drop back on an accepted reconfig.
    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        case (state_q)
            ST_LOCKING: begin
                if (lock_cnt_q == LOCK_TARGET) begin
                    state_d = ST_LOCKED;
                end else begin
                    lock_cnt_d = lock_cnt_q + LCW'(1);
                end
            end
            ST_LOCKED: begin
                if (reconf) begin
                    state_d    = ST_LOCKING;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ST_LOCKING;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Lock FSM state, settling counter and registered locked flag.
    always_ff @(posedge clk_in1 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_LOCKING;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= (state_d == ST_LOCKED);
        end
    end

    // Channels run on the next-state lock so their first active cycle matches locked=1.
    assign run    = (state_d == ST_LOCKED);
    assign locked = locked_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_gen_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .clk_in1   (clk_in1),
            .resetn    (resetn),
            .run_i     (run),
            .div_i     (ratio[i]),
            .clk_out_o (clk_out[i]),
            .clk_en_o  (clk_en[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_multi.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_gen_multi                                              |
// | Description : Randomized scoreboard bench for clk_gen_multi. Instance A is  |
// |               the default 2-channel build; instance B has 6 channels with   |
// |               ratios 0,1,2,3,7,255 and zero settling time.                  |
// |               Honours CLK_GEN_MULTI_RECONFIG_EN when defined.               |
// | Revision    : 1.0  initial release                                          |
// +----------------------------------------------------------------------------+
module tb_clk_gen_multi;

`ifdef CLK_GEN_MULTI_RECONFIG_EN
    localparam bit RECONF = 1'b1;
`else
    localparam bit RECONF = 1'b0;
`endif

    localparam int A_CH   = 2;
    localparam int A_LOCK = 16;
    localparam int B_CH   = 6;
    localparam int B_LOCK = 0;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    clk_gen_multi_if #(.DIV_W(8)) ifa ();
    clk_gen_multi_if #(.DIV_W(8)) ifb ();

    logic [A_CH-1:0] a_out, a_en;
    logic            a_lock;
    logic [B_CH-1:0] b_out, b_en;
    logic            b_lock;

    clk_gen_multi #(
        .NUM_CH      (A_CH),
        .DIV_W       (8),
        .DIV_INIT    ({8'd4, 8'd2}),
        .LOCK_CYCLES (A_LOCK)
    ) u_dut_a (
        .clk_in1 (clk),
        .resetn  (resetn),
        .cfg     (ifa.slave),
        .clk_out (a_out),
        .clk_en  (a_en),
        .locked  (a_lock)
    );

    clk_gen_multi #(
        .NUM_CH      (B_CH),
        .DIV_W       (8),
        .DIV_INIT    ({8'd255, 8'd7, 8'd3, 8'd2, 8'd1, 8'd0}),
        .LOCK_CYCLES (B_LOCK)
    ) u_dut_b (
        .clk_in1 (clk),
        .resetn  (resetn),
        .cfg     (ifb.slave),
        .clk_out (b_out),
        .clk_en  (b_en),
        .locked  (b_lock)
    );

    always #5 clk = ~clk;

    // Reference model: a global phase k counted from the lock instant.
    typedef struct {
        bit locked;
        int edges;
        int k;
        int div[8];
    } mdl_t;

    typedef struct packed {
        bit       locked;
        bit       ready;
        bit [7:0] out;
        bit [7:0] en;
    } exp_t;

    int   a_init[8] = '{2, 4, 0, 0, 0, 0, 0, 0};
    int   b_init[8] = '{0, 1, 2, 3, 7, 255, 0, 0};
    mdl_t ma, mb;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int   checks   = 0;
    int   failures = 0;

    function automatic mdl_t mreset(input int init[8]);
        mdl_t r;
        r.locked = 1'b0;
        r.edges  = 0;
        r.k      = 0;
        r.div    = init;
        return r;
    endfunction

    function automatic mdl_t mstep(input mdl_t m, input bit v, input int ch, input int dv,
                                   input int nch, input int lockc);
        mdl_t r = m;
        if (!m.locked) begin
            r.edges = m.edges + 1;
            if (r.edges == lockc + 1) begin
                r.locked = 1'b1;
                r.k      = 0;
            end
        end else if (RECONF && v && (ch < nch)) begin
            r.div[ch] = dv;
            r.locked  = 1'b0;
            r.edges   = 0;
        end else begin
            r.k = m.k + 1;
        end
        return r;
    endfunction

    function automatic exp_t mexp(input mdl_t m, input int nch);
        exp_t e = '0;
        int   d;
        e.locked = m.locked;
        e.ready  = RECONF && m.locked;
        for (int i = 0; i < nch; i++) begin
            d        = (m.div[i] < 2) ? 2 : m.div[i];
            e.out[i] = m.locked && ((m.k % d) < (d / 2));
            e.en[i]  = m.locked && ((m.k % d) == 0);
        end
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model update at each active edge from the inputs presented to the DUT.
    always @(posedge clk) begin
        if (!resetn) begin
            ma = mreset(a_init);
            mb = mreset(b_init);
        end else begin
            ma = mstep(ma, ifa.cfg_valid, int'(ifa.cfg_ch), int'(ifa.cfg_div), A_CH, A_LOCK);
            mb = mstep(mb, ifb.cfg_valid, int'(ifb.cfg_ch), int'(ifb.cfg_div), B_CH, B_LOCK);
        end
        qa.push_back(mexp(ma, A_CH));
        qb.push_back(mexp(mb, B_CH));
    end

    // Monitor: compare presented outputs against queued expectations mid-cycle.
    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            chk("a_locked",  32'(a_lock),        32'(ea.locked));
            chk("a_ready",   32'(ifa.cfg_ready), 32'(ea.ready));
            chk("a_clk_out", 32'(a_out),         32'(ea.out[A_CH-1:0]));
            chk("a_clk_en",  32'(a_en),          32'(ea.en[A_CH-1:0]));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            chk("b_locked",  32'(b_lock),        32'(eb.locked));
            chk("b_ready",   32'(ifb.cfg_ready), 32'(eb.ready));
            chk("b_clk_out", 32'(b_out),         32'(eb.out[B_CH-1:0]));
            chk("b_clk_en",  32'(b_en),          32'(eb.en[B_CH-1:0]));
        end
    end

    task automatic drive_idle();
        ifa.cfg_valid = 1'b0;
        ifa.cfg_ch    = '0;
        ifa.cfg_div   = '0;
        ifb.cfg_valid = 1'b0;
        ifb.cfg_ch    = '0;
        ifb.cfg_div   = '0;
    endtask

    task automatic drive_random(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            #2;
            ifa.cfg_valid = ($urandom_range(0, 24) == 0);
            ifa.cfg_ch    = 3'($urandom_range(0, 3));
            ifa.cfg_div   = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                       : 8'($urandom_range(0, 12));
            ifb.cfg_valid = ($urandom_range(0, 24) == 0);
            ifb.cfg_ch    = 3'($urandom_range(0, 7));
            ifb.cfg_div   = 8'($urandom_range(0, 12));
        end
    endtask

    task automatic idle_cycles(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            #2;
            drive_idle();
        end
    endtask

    initial begin
        drive_idle();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b1;

        // Initial lock and default ratios, including the full 255 period.
        idle_cycles(600);

        // Random reconfiguration traffic.
        drive_random(1500);
        idle_cycles(40);

        // Asynchronous reset mid-operation: outputs drop before any clock edge.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_a_locked", 32'(a_lock),        32'd0);
        chk("rst_async_a_out",    32'(a_out),         32'd0);
        chk("rst_async_a_en",     32'(a_en),          32'd0);
        chk("rst_async_a_ready",  32'(ifa.cfg_ready), 32'd0);
        chk("rst_async_b_locked", 32'(b_lock),        32'd0);
        chk("rst_async_b_out",    32'(b_out),         32'd0);
        chk("rst_async_b_en",     32'(b_en),          32'd0);
        repeat (2) @(negedge clk);
        #2;
        resetn = 1'b1;

        // Ratios back at DIV_INIT after reset, then more random traffic.
        idle_cycles(300);
        drive_random(500);
        idle_cycles(100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
